hazard_fwd_ctrl: RTL and testbench
==================================

HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 The block SHALL have parameter REG_AW, default 3: register-address width.
REQ-002 The block SHALL have parameter FWD_EN, default 1: 1 = forwarding mode, 0 = stall-only mode.
REQ-003 The block SHALL have parameter R0_ZERO, default 0: 1 = register 0 is hardwired, so it never creates a hazard and is never forwarded.
REQ-004 The block SHALL have parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 id_valid  input  1  a real (non-NOP) instruction is in decode.
REQ-008 id_src1_vld, id_src2_vld  input  1 each  decode reads source 1 / source 2.
REQ-009 id_src1, id_src2  input  REG_AW each  source register addresses.
REQ-010 id_wr  input  1  decode instruction writes a register.
REQ-011 id_dst  input  REG_AW  destination register address.
REQ-012 id_load  input  1  decode instruction is a memory load.
REQ-013 flush  input  1  branch/jump taken; the decode instruction is squashed.
REQ-014 ext_stall  input  1  fetch-cache or memory-cache stall; the whole pipe freezes.
REQ-015 cnt_clr  input  1  synchronous clear of stall_cnt.
REQ-016 stall  output  1  high = hold PC and IF/ID, inject a bubble into EX.
REQ-017 fwd1, fwd2  output  2 each  operand source select: 00 register file, 01 EX result, 10 MEM result, 11 WB result.
REQ-018 state  output  2  FSM state: 00 RUN, 01 HAZ, 10 FROZEN.
REQ-019 stall_cnt  output  CNT_W  count of cycles with stall high.

Function
REQ-020 The block SHALL keep three tracking slots (EX, MEM, WB), each holding {vld, wr, load, dst}.
REQ-021 Slot update when ext_stall=0 SHALL be: EX loads decode info if id_valid & ~stall & ~flush, else a bubble (vld=0); MEM takes EX; WB takes MEM.
REQ-022 While ext_stall=1, all slots SHALL hold their values, and flush and cnt_clr SHALL be ignored.
REQ-023 A source i SHALL match a slot when src_i_vld & slot.vld & slot.wr & (src_i==slot.dst) & ~(R0_ZERO & src_i==0).
REQ-024 With FWD_EN=1, fwd_i SHALL be 01 if EX matches and EX is not a load, else 10 if MEM matches, else 11 if WB matches, else 00; the youngest slot wins.
REQ-025 With FWD_EN=1, stall SHALL be high when id_valid & ~flush and either source matches an EX slot that is a load (load-use, exactly one cycle).
REQ-026 With FWD_EN=0, fwd1 and fwd2 SHALL be 00, and stall SHALL be high when id_valid & ~flush and any source matches EX, MEM or WB.
REQ-027 stall SHALL be forced low when flush=1; flush has priority over a hazard.
REQ-028 The hazard comparison SHALL be evaluated combinationally while ext_stall=1, but the slots SHALL not advance.
REQ-029 FSM transitions SHALL be: ext_stall=1 -> FROZEN from any state; else stall=1 -> HAZ; else -> RUN.
REQ-030 stall_cnt SHALL increment by 1 on each edge where stall=1 and ext_stall=0.
REQ-031 stall_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-032 When cnt_clr=1 and ext_stall=0, stall_cnt SHALL load 0; clear has priority over increment.

Reset
REQ-033 On rst_n=0, all slot vld bits SHALL clear to 0 immediately, state SHALL clear to RUN (00), and stall_cnt SHALL clear to 0, independent of clk.
REQ-034 During and after reset, until a valid instruction enters, stall SHALL be 0 and fwd1/fwd2 SHALL be 00.
REQ-035 Reset asserted mid-stall SHALL drop stall within the same cycle, because no slot is valid.

Verification
REQ-036 ALU dependency: decode ADD wr R3, next cycle decode src1=R3 -> fwd1=01, stall=0; one cycle later src2=R3 -> fwd2=10; then -> fwd2=11; then -> 00.
REQ-037 Load-use: load dst R2, next decode src1=R2 -> stall=1 for exactly 1 cycle, state=HAZ, then fwd1=10, stall_cnt=1.
REQ-038 Freeze: hazard present with ext_stall=1 for 5 cycles -> slots frozen, state=FROZEN, stall_cnt unchanged; after release the sequence resumes identically.
REQ-039 Flush: load-use hazard with flush=1 in the same cycle -> stall=0, EX receives a bubble, next cycle fwd=00.
REQ-040 Mode sweep: FWD_EN=0, ADD wr R5 then src1=R5 -> stall=1 for 3 cycles, stall_cnt=3; R0_ZERO=1 with src=R0 matching dst=R0 -> no stall, fwd=00.
REQ-041 Counter edges: CNT_W=2 with 5 stall cycles -> stall_cnt holds at 3; cnt_clr coincident with stall -> 0; rst_n pulsed low mid-HAZ -> state=00 and stall=0 asynchronously.

Source files
------------

// File: rtl/hazard_fwd_ctrl.sv
// Decode-stage hazard detection and operand forwarding control for a 5-stage pipe.
// Latency: stall/fwd are combinational from decode inputs and tracked slots; state/stall_cnt registered.
// Backpressure: ext_stall freezes all tracking; stall holds PC and IF/ID and bubbles EX.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   id_valid, id_src*_vld/src*  decode instruction and its source operands
//   id_wr, id_dst, id_load      decode instruction's destination and load flag
//   flush                       decode instruction squashed (branch/jump taken)
//   ext_stall                   whole-pipe freeze from the caches
//   cnt_clr                     synchronous clear of stall_cnt
//   stall, fwd1, fwd2           hazard stall and operand source selects
//   state                       00 RUN, 01 HAZ, 10 FROZEN
//   stall_cnt                   saturating count of stall cycles
module hazard_fwd_ctrl #(
    parameter int REG_AW  = 3,
    parameter int FWD_EN  = 1,
    parameter int R0_ZERO = 0,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              id_src1_vld,
    input  logic              id_src2_vld,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_wr,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_load,
    input  logic              flush,
    input  logic              ext_stall,
    input  logic              cnt_clr,
    output logic              stall,
    output logic [1:0]        fwd1,
    output logic [1:0]        fwd2,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic              vld;
        logic              wr;
        logic              load;
        logic [REG_AW-1:0] dst;
    } slot_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_HAZ    = 2'b01,
        ST_FROZEN = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    slot_t            ex_q, mem_q, wb_q;
    slot_t            id_slot;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;

    // Register 0 is excluded from matching when it is hardwired to zero.
    function automatic logic hit(input logic src_vld, input logic [REG_AW-1:0] src,
                                 input slot_t s);
        return src_vld && s.vld && s.wr && (src == s.dst) &&
               !((R0_ZERO != 0) && (src == '0));
    endfunction

    // Youngest producer wins; a load in EX has no result yet, so it is skipped
    // and the load-use stall covers that case.
    function automatic logic [1:0] pick(input logic m_ex, input logic ex_load,
                                        input logic m_mem, input logic m_wb);
        if (m_ex && !ex_load) return 2'b01;
        else if (m_mem)       return 2'b10;
        else if (m_wb)        return 2'b11;
        else                  return 2'b00;
    endfunction

    logic s1_ex, s1_mem, s1_wb, s2_ex, s2_mem, s2_wb;
    logic hazard;

    always_comb begin
        s1_ex  = hit(id_src1_vld, id_src1, ex_q);
        s1_mem = hit(id_src1_vld, id_src1, mem_q);
        s1_wb  = hit(id_src1_vld, id_src1, wb_q);
        s2_ex  = hit(id_src2_vld, id_src2, ex_q);
        s2_mem = hit(id_src2_vld, id_src2, mem_q);
        s2_wb  = hit(id_src2_vld, id_src2, wb_q);

        if (FWD_EN != 0) begin
            hazard = (s1_ex || s2_ex) && ex_q.load;
            fwd1   = pick(s1_ex, ex_q.load, s1_mem, s1_wb);
            fwd2   = pick(s2_ex, ex_q.load, s2_mem, s2_wb);
        end else begin
            hazard = s1_ex || s1_mem || s1_wb || s2_ex || s2_mem || s2_wb;
            fwd1   = 2'b00;
            fwd2   = 2'b00;
        end

        // Flush squashes the decode instruction, so it can never stall.
        stall = id_valid && !flush && hazard;

        id_slot.vld  = id_valid && !stall && !flush;
        id_slot.wr   = id_wr;
        id_slot.load = id_load;
        id_slot.dst  = id_dst;
    end

    // Tracking slots: frozen under ext_stall, otherwise shift EX->MEM->WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!ext_stall) begin
            ex_q  <= id_slot.vld ? id_slot : slot_t'('0);
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else if (ext_stall) begin
            state_q <= ST_FROZEN;
        end else if (stall) begin
            state_q <= ST_HAZ;
        end else begin
            state_q <= ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!ext_stall) begin
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (stall && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign state     = state_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: three instances share stimulus.
// a: defaults (forwarding), b: stall-only with hardwired R0, c: stall-only with 2-bit counter.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_hazard_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_src1_vld, id_src2_vld, id_wr, id_load;
    logic [2:0] id_src1, id_src2, id_dst;
    logic       flush, ext_stall, cnt_clr;

    logic        a_stall, b_stall, c_stall;
    logic [1:0]  a_fwd1, a_fwd2, b_fwd1, b_fwd2, c_fwd1, c_fwd2;
    logic [1:0]  a_state, b_state, c_state;
    logic [15:0] a_cnt, b_cnt;
    logic [1:0]  c_cnt;

    int checks;
    int failures;

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(.REG_AW(3), .FWD_EN(1), .R0_ZERO(0), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_src1_vld(id_src1_vld), .id_src2_vld(id_src2_vld),
        .id_src1(id_src1), .id_src2(id_src2), .id_wr(id_wr), .id_dst(id_dst),
        .id_load(id_load), .flush(flush), .ext_stall(ext_stall), .cnt_clr(cnt_clr),
        .stall(a_stall), .fwd1(a_fwd1), .fwd2(a_fwd2), .state(a_state), .stall_cnt(a_cnt)
    );

    hazard_fwd_ctrl #(.REG_AW(3), .FWD_EN(0), .R0_ZERO(1), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_src1_vld(id_src1_vld), .id_src2_vld(id_src2_vld),
        .id_src1(id_src1), .id_src2(id_src2), .id_wr(id_wr), .id_dst(id_dst),
        .id_load(id_load), .flush(flush), .ext_stall(ext_stall), .cnt_clr(cnt_clr),
        .stall(b_stall), .fwd1(b_fwd1), .fwd2(b_fwd2), .state(b_state), .stall_cnt(b_cnt)
    );

    hazard_fwd_ctrl #(.REG_AW(3), .FWD_EN(0), .R0_ZERO(0), .CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_src1_vld(id_src1_vld), .id_src2_vld(id_src2_vld),
        .id_src1(id_src1), .id_src2(id_src2), .id_wr(id_wr), .id_dst(id_dst),
        .id_load(id_load), .flush(flush), .ext_stall(ext_stall), .cnt_clr(cnt_clr),
        .stall(c_stall), .fwd1(c_fwd1), .fwd2(c_fwd2), .state(c_state), .stall_cnt(c_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic dec(input logic v, input logic s1v, input logic [2:0] s1,
                       input logic s2v, input logic [2:0] s2,
                       input logic wr, input logic [2:0] dst, input logic ld);
        id_valid    = v;
        id_src1_vld = s1v;
        id_src1     = s1;
        id_src2_vld = s2v;
        id_src2     = s2;
        id_wr       = wr;
        id_dst      = dst;
        id_load     = ld;
    endtask

    task automatic idle();
        dec(0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        ext_stall = 1'b0;
        cnt_clr   = 1'b0;
        idle();

        // Reset state
        #2;
        chk("rst_state", a_state, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_stall", a_stall, 0);
        chk("rst_fwd1", a_fwd1, 0);
        chk("rst_fwd2", a_fwd2, 0);
        chk("rst_c_cnt", c_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU dependency: ADD wr R3, then consumers walk through EX/MEM/WB
        dec(1, 0, 3'd0, 0, 3'd0, 1, 3'd3, 0); #1;
        chk("alu_prod_stall", a_stall, 0);
        tick();
        dec(1, 1, 3'd3, 0, 3'd0, 0, 3'd0, 0); #1;
        chk("alu_fwd1_ex", a_fwd1, 1);
        chk("alu_stall", a_stall, 0);
        tick();
        dec(1, 0, 3'd0, 1, 3'd3, 0, 3'd0, 0); #1;
        chk("alu_fwd2_mem", a_fwd2, 2);
        tick(); #1;
        chk("alu_fwd2_wb", a_fwd2, 3);
        tick(); #1;
        chk("alu_fwd2_rf", a_fwd2, 0);
        idle();
        tick(); tick(); tick();

        // Load-use: LD R2, then src1=R2
        dec(1, 0, 3'd0, 0, 3'd0, 1, 3'd2, 1);
        tick();
        dec(1, 1, 3'd2, 0, 3'd0, 0, 3'd0, 0); #1;
        chk("lu_stall", a_stall, 1);
        chk("lu_fwd1_hold", a_fwd1, 0);
        chk("lu_state_run", a_state, 0);
        tick(); #1;
        chk("lu_stall_drop", a_stall, 0);
        chk("lu_state_haz", a_state, 1);
        chk("lu_fwd1_mem", a_fwd1, 2);
        chk("lu_cnt", a_cnt, 1);
        tick();
        idle(); #1;
        chk("lu_state_back", a_state, 0);
        tick(); tick();

        // Freeze: load-use hazard held under ext_stall for 5 cycles
        dec(1, 0, 3'd0, 0, 3'd0, 1, 3'd4, 1);
        tick();
        dec(1, 1, 3'd4, 0, 3'd0, 0, 3'd0, 0);
        ext_stall = 1'b1; #1;
        chk("frz_stall_comb", a_stall, 1);
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            chk("frz_state", a_state, 2);
            chk("frz_cnt", a_cnt, 1);
            chk("frz_stall", a_stall, 1);
        end
        chk("frz_fwd1", a_fwd1, 0);
        ext_stall = 1'b0; #1;
        chk("frz_rel_stall", a_stall, 1);
        tick(); #1;
        chk("frz_rel_state", a_state, 1);
        chk("frz_rel_cnt", a_cnt, 2);
        chk("frz_rel_stall2", a_stall, 0);
        chk("frz_rel_fwd1", a_fwd1, 2);
        idle();
        tick(); tick(); tick();

        // Flush: load-use consumer (wr R7) flushed in the same cycle
        dec(1, 0, 3'd0, 0, 3'd0, 1, 3'd6, 1);
        tick();
        dec(1, 1, 3'd6, 0, 3'd0, 1, 3'd7, 0);
        flush = 1'b1; #1;
        chk("fl_stall", a_stall, 0);
        tick();
        flush = 1'b0;
        dec(1, 1, 3'd7, 1, 3'd6, 0, 3'd0, 0); #1;
        chk("fl_fwd1_bubble", a_fwd1, 0);
        chk("fl_fwd2_mem", a_fwd2, 2);
        chk("fl_stall2", a_stall, 0);
        chk("fl_cnt", a_cnt, 2);
        chk("fl_state", a_state, 0);
        idle();
        tick(); tick(); tick();

        // Clean start for the mode sweep
        rst_n = 1'b0; #1;
        chk("rst2_b_cnt", b_cnt, 0);
        chk("rst2_b_state", b_state, 0);
        #1;
        rst_n = 1'b1;

        // Stall-only mode: ADD wr R5, then src1=R5 stalls for 3 cycles
        dec(1, 0, 3'd0, 0, 3'd0, 1, 3'd5, 0);
        tick();
        dec(1, 1, 3'd5, 0, 3'd0, 0, 3'd0, 0); #1;
        chk("so_stall_ex", b_stall, 1);
        chk("so_fwd1", b_fwd1, 0);
        chk("so_a_fwd1", a_fwd1, 1);
        tick(); #1;
        chk("so_stall_mem", b_stall, 1);
        tick(); #1;
        chk("so_stall_wb", b_stall, 1);
        tick(); #1;
        chk("so_stall_done", b_stall, 0);
        chk("so_cnt", b_cnt, 3);
        chk("so_state", b_state, 1);
        chk("so_c_cnt_sat", c_cnt, 3);
        idle();
        tick(); tick(); tick();

        // R0 hardwired: dst=R0 then src=R0 must not stall in b; c has no R0 rule
        dec(1, 0, 3'd0, 0, 3'd0, 1, 3'd0, 0);
        tick();
        dec(1, 1, 3'd0, 1, 3'd0, 0, 3'd0, 0); #1;
        chk("r0_b_stall", b_stall, 0);
        chk("r0_b_fwd1", b_fwd1, 0);
        chk("r0_b_fwd2", b_fwd2, 0);
        chk("r0_a_fwd1", a_fwd1, 1);
        chk("r0_c_stall", c_stall, 1);
        tick(); tick(); tick(); #1;
        chk("sat_c_cnt", c_cnt, 3);
        chk("sat_c_stall_done", c_stall, 0);
        idle();
        tick(); tick(); tick();

        // Clear coincident with a stall, then async reset mid-HAZ
        dec(1, 0, 3'd0, 0, 3'd0, 1, 3'd3, 0);
        tick();
        dec(1, 1, 3'd3, 0, 3'd0, 0, 3'd0, 0);
        cnt_clr = 1'b1; #1;
        chk("clr_c_stall", c_stall, 1);
        tick();
        cnt_clr = 1'b0; #1;
        chk("clr_c_cnt", c_cnt, 0);
        chk("clr_c_state", c_state, 1);
        chk("clr_c_stall2", c_stall, 1);
        tick(); #1;
        chk("clr_c_cnt_inc", c_cnt, 1);
        chk("midhaz_state", c_state, 1);
        chk("midhaz_stall", c_stall, 1);
        rst_n = 1'b0; #1;
        chk("arst_state", c_state, 0);
        chk("arst_stall", c_stall, 0);
        chk("arst_cnt", c_cnt, 0);
        chk("arst_b_stall", b_stall, 0);
        #1;
        rst_n = 1'b1;
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
